// File: rtl/piso_serializer_if.sv
// Handshake and serial-side signal bundle for piso_serializer.
// The slave modport is the serializer; the master modport is the word source / serial consumer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_en;
  logic             Dout;
  logic             dout_valid;
  logic             dout_first;
  logic             dout_last;
  logic             busy;

  modport slave (
    input  in_data,
    input  in_valid,
    input  ser_en,
    output in_ready,
    output Dout,
    output dout_valid,
    output dout_first,
    output dout_last,
    output busy
  );

  modport master (
    output in_data,
    output in_valid,
    output ser_en,
    input  in_ready,
    input  Dout,
    input  dout_valid,
    input  dout_first,
    input  dout_last,
    input  busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready word input and framed serial output.
// Every serial output is a flop; only in_ready is combinational (on state, cnt, ser_en, rst).
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             ready_s;
  logic             accept_s;

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    logic b;
    if (MSB_FIRST) begin
      b = v[WIDTH-1];
    end else begin
      b = v[0];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {v[WIDTH-2:0], 1'b0};
    end else begin
      r = {1'b0, v[WIDTH-1:1]};
    end
    return r;
  endfunction

  // Ready decode: idle, or the last bit is leaving on this edge.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      IDLE:    ready_s = 1'b1;
      SHIFT:   ready_s = (cnt_q == LAST_CNT) && bus.ser_en;
      default: ready_s = 1'b0;
    endcase
    accept_s = ready_s && bus.in_valid;
  end

  // Next-state, shift and registered-output computation.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sreg_d  = bus.in_data;
          cnt_d   = {CW{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!bus.ser_en) begin
          state_d = SHIFT;
        end else if (cnt_q != LAST_CNT) begin
          sreg_d = shift_toward_out(sreg_q);
          cnt_d  = cnt_q + CW'(1);
        end else if (bus.in_valid) begin
          sreg_d  = bus.in_data;
          cnt_d   = {CW{1'b0}};
          state_d = SHIFT;
        end else begin
          sreg_d  = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = IDLE;
        end
      end
      default: begin
        sreg_d  = {WIDTH{1'b0}};
        cnt_d   = {CW{1'b0}};
        state_d = IDLE;
      end
    endcase

    if (state_d == SHIFT) begin
      dout_d  = out_bit(sreg_d);
      valid_d = 1'b1;
      first_d = (cnt_d == {CW{1'b0}});
      last_d  = (cnt_d == LAST_CNT);
    end else begin
      dout_d  = 1'b0;
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // State, shift register, counter and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready   = ready_s & ~rst;
  assign bus.Dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.dout_first = first_q;
  assign bus.dout_last  = last_q;
  assign bus.busy       = valid_q;

endmodule
